// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable frame format and a show-ahead output FIFO.
// Frames are pushed on the final stop sample; a full FIFO drops the frame and pulses overrun.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQUENCY_HZ = 100_000_000,
  parameter int unsigned BAUD             = 9600,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY           = 0,
  parameter int unsigned STOP_BITS        = 1,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV = CLK_FREQUENCY_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned EW  = DATA_BITS + 2;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  logic                 rx_meta_q, rx_sync_q;
  logic [TW-1:0]        tick_cnt_q;
  logic                 tick;
  state_e               state_q, state_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 stop2_q, stop2_d;
  logic                 push, push_ferr, perr;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_q, rd_q;
  logic                 overrun_q;
  logic                 empty, full, pop, wr_en;
  logic [EW-1:0]        head;

  assign tick = (tick_cnt_q == TICK_LAST);
  assign perr = (PARITY != 0) && ((^shreg_q ^ par_q) != (PARITY == 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      tick_cnt_q <= '0;
      state_q    <= S_IDLE;
      samp_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      ferr_q     <= ferr_d;
      stop2_q    <= stop2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    ferr_d    = ferr_q;
    stop2_d   = stop2_q;
    push      = 1'b0;
    push_ferr = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_d = S_START;
            samp_d  = '0;
          end
        end
        S_START: begin
          if (samp_q == SAMP_MID) begin
            samp_d = '0;
            if (rx_sync_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              bit_d   = '0;
              ferr_d  = 1'b0;
              stop2_d = 1'b0;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        S_DATA: begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            // LSB arrives first, so shift in at the top and move right
            shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            par_d   = rx_sync_q;
            state_d = S_STOP;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        S_STOP: begin
          if (samp_q == SAMP_LAST) begin
            samp_d = '0;
            if ((STOP_BITS == 2) && !stop2_q) begin
              stop2_d = 1'b1;
              ferr_d  = !rx_sync_q;
            end else begin
              push      = 1'b1;
              push_ferr = ferr_q | !rx_sync_q;
              state_d   = push_ferr ? S_BREAK : S_IDLE;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_sync_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      overrun_q <= push && full && !pop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= {push_ferr, perr, shreg_q};
  end

  assign head       = mem_q[rd_q[AW-1:0]];
  assign valid      = !empty;
  assign data       = valid ? head[DATA_BITS-1:0] : '0;
  assign parity_err = valid & head[DATA_BITS];
  assign frame_err  = valid & head[DATA_BITS+1];
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1 and 8E1 receivers at 160 clk per bit.
module tb_uart_rx_cfg;

  logic       clk, rst;
  logic       rx0, rx1, ready0, ready1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, ferr0, ferr1, perr0, perr1, ovr0, ovr1, busy0, busy1;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt  = 0;
  logic [9:0] cap0[$];
  logic [9:0] cap1[$];

  uart_rx_cfg #(
    .CLK_FREQUENCY_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .rst(rst), .uart_rx(rx0), .data(data0), .valid(valid0), .ready(ready0),
    .frame_err(ferr0), .parity_err(perr0), .overrun(ovr0), .busy(busy0)
  );

  uart_rx_cfg #(
    .CLK_FREQUENCY_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_p (
    .clk(clk), .rst(rst), .uart_rx(rx1), .data(data1), .valid(valid1), .ready(ready1),
    .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid0 && ready0) cap0.push_back({ferr0, perr0, data0});
      if (valid1 && ready1) cap1.push_back({ferr1, perr1, data1});
      if (ovr0) ovr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) rx1 = v;
    else       rx0 = v;
  endtask

  task automatic send(input logic [7:0] d, input logic has_par, input logic pbit,
                      input logic stopv, input bit which);
    set_line(which, 1'b0);
    wait_clks(160);
    for (int i = 0; i < 8; i++) begin
      set_line(which, d[i]);
      wait_clks(160);
    end
    if (has_par) begin
      set_line(which, pbit);
      wait_clks(160);
    end
    set_line(which, stopv);
    wait_clks(160);
  endtask

  task automatic take0(input string tag, input logic [9:0] exp);
    logic [9:0] e;
    chk({tag, "_present"}, 32'(cap0.size() != 0), 32'd1);
    if (cap0.size() != 0) begin
      e = cap0.pop_front();
      chk(tag, 32'(e), 32'(exp));
    end
  endtask

  task automatic take1(input string tag, input logic [9:0] exp);
    logic [9:0] e;
    chk({tag, "_present"}, 32'(cap1.size() != 0), 32'd1);
    if (cap1.size() != 0) begin
      e = cap1.pop_front();
      chk(tag, 32'(e), 32'(exp));
    end
  endtask

  initial begin
    int base;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    wait_clks(5);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_busy",  32'(busy0),  32'd0);
    chk("rst_data",  32'(data0),  32'd0);
    chk("rst_ovr",   32'(ovr0),   32'd0);
    chk("rst_ferr",  32'(ferr0),  32'd0);
    chk("rst_perr",  32'(perr1),  32'd0);
    chk("rst_busy_p", 32'(busy1), 32'd0);
    rst = 1'b0;
    wait_clks(20);

    // 8N1 basic frame
    send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(160);
    take0("a5_entry", {2'b00, 8'hA5});
    chk("a5_count", 32'(cap0.size()), 32'd0);
    chk("a5_busy",  32'(busy0), 32'd0);
    chk("a5_valid", 32'(valid0), 32'd0);

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong and 1 is right
    send(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_clks(160);
    take1("par_bad", {2'b01, 8'h07});
    send(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_clks(160);
    take1("par_ok", {2'b00, 8'h07});

    // Start-bit glitch
    rx0 = 1'b0;
    wait_clks(20);
    chk("glitch_busy_hi", 32'(busy0), 32'd1);
    wait_clks(20);
    rx0 = 1'b1;
    wait_clks(160);
    chk("glitch_busy_lo", 32'(busy0), 32'd0);
    chk("glitch_nopush", 32'(cap0.size()), 32'd0);

    // Frame error followed by a held break, then a clean frame
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_clks(320);
    chk("brk_busy", 32'(busy0), 32'd1);
    take0("ferr_entry", {2'b10, 8'h3C});
    rx0 = 1'b1;
    wait_clks(40);
    chk("brk_exit", 32'(busy0), 32'd0);
    wait_clks(120);
    send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(160);
    take0("after_brk", {2'b00, 8'h55});

    // Overrun on the fifth frame with the consumer stalled
    ready0 = 1'b0;
    base = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
      wait_clks(160);
      if (i == 4) begin
        chk("ovr_none_yet", 32'(ovr_cnt - base), 32'd0);
        chk("full_valid", 32'(valid0), 32'd1);
      end
    end
    chk("ovr_once", 32'(ovr_cnt - base), 32'd1);
    chk("ovr_head", 32'(data0), 32'h01);
    ready0 = 1'b1;
    wait_clks(10);
    chk("drain_count", 32'(cap0.size()), 32'd4);
    for (int i = 1; i <= 4; i++) take0("drain", {2'b00, 8'(i)});
    chk("drain_empty", 32'(valid0), 32'd0);

    // Reset mid data bit 3 with a stored entry pending
    ready0 = 1'b0;
    send(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(160);
    chk("pre_rst_valid", 32'(valid0), 32'd1);
    rx0 = 1'b0;
    wait_clks(160);
    rx0 = 1'b1; wait_clks(160);
    rx0 = 1'b1; wait_clks(160);
    rx0 = 1'b0; wait_clks(160);
    rx0 = 1'b1; wait_clks(80);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    chk("midrst_valid", 32'(valid0), 32'd0);
    chk("midrst_busy",  32'(busy0),  32'd0);
    chk("midrst_data",  32'(data0),  32'd0);
    ready0 = 1'b1;
    wait_clks(160);
    send(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(160);
    take0("post_rst", {2'b00, 8'h81});
    chk("post_rst_count", 32'(cap0.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
